risc_datapath: RTL

RISC_DATAPATH -- requirements
Module: risc_datapath

---
 rtl/risc_datapath.sv | 88 ++++++++
 1 files changed

// File: rtl/risc_datapath.sv
// Accumulator datapath for the 8-bit RISC core: PC, IR, ACC, MDR, ALU, halt latch.
// Controller strobes arrive registered-free; memory-side outputs are combinational.
module risc_datapath (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       rd,
  input  logic       ld_ir,
  input  logic       halt,
  input  logic       inc_pc,
  input  logic       ld_ac,
  input  logic       ld_pc,
  input  logic       wr,
  input  logic       data_e,
  input  logic       load,
  input  logic       addr_mux,
  input  logic [7:0] mem_rdata,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [2:0] opcode,
  output logic       is_zero,
  output logic       halted,
  output logic [4:0] pc,
  output logic [7:0] acc,
  output logic [7:0] instr_count
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;

  logic [DW-1:0] ir;
  logic [DW-1:0] mdr;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_y;
  logic          ir_we;

  assign ir_we = ld_ir & rd & ~halted;

  // Memory-side view; strobes are blocked once halted and while in reset.
  assign mem_addr  = (addr_mux || !sel) ? ir[AW-1:0] : pc;
  assign mem_wdata = data_e ? acc : '0;
  assign mem_rd    = rd & ~halted & ~rst;
  assign mem_wr    = wr & ~halted & ~rst;
  assign opcode    = ir[7:5];
  assign is_zero   = (acc == '0);

  // B operand bypasses MDR so an operand fetch can feed the ALU in the same cycle.
  always_comb begin
    alu_b = load ? mem_rdata : mdr;
    alu_y = acc;
    case (ir[7:5])
      OP_ADD:  alu_y = DW'(acc + alu_b);
      OP_AND:  alu_y = acc & alu_b;
      OP_XOR:  alu_y = acc ^ alu_b;
      OP_LDA:  alu_y = alu_b;
      default: alu_y = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      ir          <= '0;
      acc         <= '0;
      mdr         <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      if (ir_we) ir <= mem_rdata;
      if (load && rd) mdr <= mem_rdata;
      if (ld_ac && !halted) acc <= alu_y;
      if (!halted) begin
        if (ld_pc)       pc <= ir[AW-1:0];
        else if (inc_pc) pc <= AW'(pc + AW'(1));
      end
      if (halt) halted <= 1'b1;
      if (ir_we && instr_count != '1) instr_count <= DW'(instr_count + DW'(1));
    end
  end

endmodule
